accumulator: RTL and testbench
==============================

ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 Parameter: PSUM_W, 8, width of signed partial-sum input and result.
REQ-002 Parameter: ACC_W, 20, width of signed internal accumulator entries.
REQ-003 Parameter: MAX_OFMAP, 1024, depth of the accumulation buffer (max ofmap positions).
REQ-004 Parameter: SIZE_W, 10, width of ofmap_size; CH_W, 8, width of ifmap_ch.
REQ-005 Port: clk  input  1  single clock, all logic on rising edge.
REQ-006 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port: psum_i  input  PSUM_W  signed partial sum for current (channel, position).
REQ-008 Port: pvaild_i  input  1  psum_i valid (port name spelled exactly so).
REQ-009 Port: pready_o  output  1  accumulator can accept a psum.
REQ-010 Port: ofmap_size  input  SIZE_W  number of ofmap positions minus 1.
REQ-011 Port: ifmap_ch  input  CH_W  number of input channels minus 1.
REQ-012 Port: conv_valid_o  output  1  conv_result_o valid, one-cycle pulse per position.
REQ-013 Port: last_o  output  1  marks final position of the tile, coincident with conv_valid_o.
REQ-014 Port: conv_result_o  output  PSUM_W  signed final result for one position.

Function
REQ-015 A transfer occurs on a rising edge where pvaild_i and pready_o are both 1; no other edge changes counters or buffer.
REQ-016 pready_o SHALL be 1 in every cycle after reset release; the block sustains one transfer per cycle without back-pressure.
REQ-017 Input order is channel-major: channel 0 positions 0..ofmap_size, then channel 1, ... up to channel ifmap_ch.
REQ-018 Position counter pos increments per transfer, wraps to 0 after ofmap_size and then increments channel counter ch.
REQ-019 ofmap_size and ifmap_ch are latched at the first transfer of a tile (IDLE state) and held until the tile ends; changes mid-tile are ignored.
REQ-020 States: IDLE (no tile active), ACC (ch < latched ifmap_ch), FINAL (ch == latched ifmap_ch); IDLE->ACC on first transfer (or IDLE->FINAL if ifmap_ch==0), ACC->FINAL when ch reaches ifmap_ch, FINAL->IDLE after transfer at pos==ofmap_size.
REQ-021 Channel 0 transfer writes sign-extended psum_i into buffer[pos] (overwrite, no clear needed); later non-final channels write buffer[pos]+psum_i.
REQ-022 Accumulator arithmetic is signed ACC_W-bit, no intermediate saturation.
REQ-023 In FINAL, sum = buffer[pos]+psum_i (psum_i alone if ifmap_ch==0); result registered to conv_result_o with conv_valid_o=1 on the edge after the transfer (latency 1 cycle).
REQ-024 Final result is clamped to [-128, 127] (see REQ-030).
REQ-025 last_o=1 together with conv_valid_o for pos==ofmap_size of the final channel, else 0.
REQ-026 conv_valid_o and last_o are 0 in any cycle not following a FINAL transfer; conv_result_o holds last value.
REQ-027 A new tile may start on the cycle immediately after the last transfer, with no idle cycle.

Reset
REQ-028 While rst_n==0 at a rising edge: state=IDLE, pos=0, ch=0, pready_o=0, conv_valid_o=0, last_o=0, conv_result_o=0; buffer contents not reset.
REQ-029 Reset asserted mid-tile aborts the tile; partial sums are discarded and the next transfer starts channel 0, position 0.

Configuration
REQ-030 Macro ACC_SATURATE_EN: defined -> final result saturated to [-128,127]; undefined -> final result is the low PSUM_W bits of the sum (two's-complement wrap).

Structure
REQ-031 Package acc_pkg holds PSUM_W/ACC_W/MAX_OFMAP/SIZE_W/CH_W defaults and the state enum typedef.
REQ-032 One sub-module psum_buffer: MAX_OFMAP x ACC_W register array, combinational read by pos, synchronous write on transfer.

Verification
REQ-033 ifmap_ch=15, ofmap_size=783, random psums in [-128,127] continuous: 784 results equal clamped column sums, last_o on result 783 only.
REQ-034 ifmap_ch=1, ofmap_size=0: psums 100, 100 -> conv_result_o=127; psums -100, -100 -> -128.
REQ-035 ifmap_ch=0, ofmap_size=2: psums 5, -7, 0 -> results 5, -7, 0 each one cycle later, last_o with 0.
REQ-036 Two back-to-back tiles (ifmap_ch=2, ofmap_size=3): second tile results unaffected by first tile buffer contents.
REQ-037 rst_n low for one cycle mid-tile, then full tile 3 ch x 4 pos of value 1 -> four results of 3, no stale output.
REQ-038 pvaild_i gapped every other cycle with ifmap_ch=1, psums 60 and 70 -> result 127 with ACC_SATURATE_EN, -126 without.

Source files
------------

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
//   Shared defaults and types for the partial-sum accumulator.
//   Contents:
//     DEF_PSUM_W    width of signed partial-sum input and of the result
//     DEF_ACC_W     width of signed internal accumulator entries
//     DEF_MAX_OFMAP depth of the accumulation buffer (ofmap positions)
//     DEF_SIZE_W    width of the ofmap_size configuration input
//     DEF_CH_W      width of the ifmap_ch configuration input
//     acc_state_e   tile FSM state encoding
//   Configuration macro: ACC_SATURATE_EN (used by accumulator.sv).
// ---------------------------------------------------------------------------
package acc_pkg;

    localparam int DEF_PSUM_W    = 8;
    localparam int DEF_ACC_W     = 20;
    localparam int DEF_MAX_OFMAP = 1024;
    localparam int DEF_SIZE_W    = 10;
    localparam int DEF_CH_W      = 8;

    // IDLE  : no tile in progress, configuration is taken from the inputs
    // ACC   : channels before the last one, results go back into the buffer
    // FINAL : last channel, every transfer produces one output result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FINAL = 2'd2
    } acc_state_e;

endpackage

// File: rtl/psum_buffer.sv
// ---------------------------------------------------------------------------
// psum_buffer
//   Register array holding one running partial sum per ofmap position.
//   Read is combinational so the accumulator can add and write back in the
//   same cycle; write is synchronous. Contents are intentionally not reset:
//   channel 0 of every tile overwrites each entry before it is read.
//   Ports:
//     clk      clock, rising edge
//     we       write enable (one accepted non-final transfer)
//     waddr    write address (ofmap position)
//     wdata    value written
//     raddr    read address (ofmap position)
//     rdata    combinational read data
// ---------------------------------------------------------------------------
module psum_buffer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/accumulator.sv
// ---------------------------------------------------------------------------
// accumulator
//   Accumulates channel-major partial sums over ifmap_ch+1 input channels for
//   ofmap_size+1 output positions, then emits one result per position.
//   Input order: channel 0 positions 0..ofmap_size, channel 1 ..., up to the
//   last channel. During the last channel each transfer produces a result one
//   cycle later.
//
//   Handshake: a transfer happens on a rising edge where pvaild_i and
//   pready_o are both 1. pready_o is 0 during reset and 1 in every cycle after
//   it, so the block never back-pressures. conv_valid_o is a one-cycle pulse
//   with no ready; conv_result_o holds its last value between pulses.
//
//   Configuration macro ACC_SATURATE_EN:
//     defined   -> final result saturated to the signed PSUM_W range
//     undefined -> final result is the low PSUM_W bits of the sum (wrap)
//
//   Ports:
//     clk            clock, rising edge
//     rst_n          synchronous active-low reset
//     psum_i         signed partial sum for the current (channel, position)
//     pvaild_i       psum_i valid
//     pready_o       accumulator can accept a psum
//     ofmap_size     number of ofmap positions minus 1 (latched per tile)
//     ifmap_ch       number of input channels minus 1 (latched per tile)
//     conv_valid_o   conv_result_o valid, one pulse per position
//     last_o         final position of the tile, coincident with conv_valid_o
//     conv_result_o  signed final result for one position
//     state_dbg_o    current FSM state (acc_state_e encoding), debug only
// ---------------------------------------------------------------------------
module accumulator
    import acc_pkg::*;
#(
    parameter int PSUM_W    = DEF_PSUM_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_OFMAP = DEF_MAX_OFMAP,
    parameter int SIZE_W    = DEF_SIZE_W,
    parameter int CH_W      = DEF_CH_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PSUM_W-1:0] psum_i,
    input  logic              pvaild_i,
    output logic              pready_o,
    input  logic [SIZE_W-1:0] ofmap_size,
    input  logic [CH_W-1:0]   ifmap_ch,
    output logic              conv_valid_o,
    output logic              last_o,
    output logic [PSUM_W-1:0] conv_result_o,
    output logic [1:0]        state_dbg_o
);

    localparam int AW = $clog2(MAX_OFMAP);

    // Result range for saturation, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((1 <<< (PSUM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(-(1 <<< (PSUM_W - 1)));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    acc_state_e         state_q;
    logic [SIZE_W-1:0]  pos_q;
    logic [CH_W-1:0]    ch_q;
    logic [SIZE_W-1:0]  size_q;
    logic [CH_W-1:0]    nch_q;
    logic               pready_q;
    logic               conv_valid_q;
    logic               last_q;
    logic [PSUM_W-1:0]  result_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                     xfer;
    logic [SIZE_W-1:0]        eff_size;
    logic [CH_W-1:0]          eff_nch;
    logic [CH_W-1:0]          ch_inc;
    logic                     first_ch;
    logic                     final_ch;
    logic                     pos_last;
    logic signed [ACC_W-1:0]  psum_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]         buf_rdata;
    logic                     buf_we;
    logic [PSUM_W-1:0]        res_next;

    assign xfer = pvaild_i & pready_q;

    always_comb begin
        // The first transfer of a tile happens in IDLE, before the latch
        // registers are loaded, so it must see the live configuration.
        eff_size = size_q;
        eff_nch  = nch_q;
        if (state_q == ST_IDLE) begin
            eff_size = ofmap_size;
            eff_nch  = ifmap_ch;
        end
        ch_inc   = ch_q + 1'b1;
        first_ch = (ch_q == '0);
        final_ch = (ch_q == eff_nch);
        pos_last = (pos_q == eff_size);
    end

    assign psum_ext = {{(ACC_W - PSUM_W){psum_i[PSUM_W-1]}}, psum_i};

    // Channel 0 ignores the buffer: whatever an earlier tile left there is
    // simply overwritten, so the buffer never needs clearing.
    assign sum    = (first_ch ? '0 : $signed(buf_rdata)) + psum_ext;
    assign buf_we = xfer & ~final_ch;

    always_comb begin
`ifdef ACC_SATURATE_EN
        res_next = sum[PSUM_W-1:0];
        if (sum > RES_MAX) begin
            res_next = RES_MAX[PSUM_W-1:0];
        end else if (sum < RES_MIN) begin
            res_next = RES_MIN[PSUM_W-1:0];
        end
`else
        res_next = sum[PSUM_W-1:0];
`endif
    end

    psum_buffer #(
        .DEPTH (MAX_OFMAP),
        .WIDTH (ACC_W),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (AW'(pos_q)),
        .wdata (sum),
        .raddr (AW'(pos_q)),
        .rdata (buf_rdata)
    );

    // ------------------------------------------------------------------
    // Tile FSM, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            ch_q         <= '0;
            size_q       <= '0;
            nch_q        <= '0;
            pready_q     <= 1'b0;
            conv_valid_q <= 1'b0;
            last_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            pready_q     <= 1'b1;
            conv_valid_q <= 1'b0;
            last_q       <= 1'b0;

            if (xfer) begin
                if (state_q == ST_IDLE) begin
                    size_q <= ofmap_size;
                    nch_q  <= ifmap_ch;
                end

                if (final_ch) begin
                    conv_valid_q <= 1'b1;
                    last_q       <= pos_last;
                    result_q     <= res_next;
                end

                if (pos_last) begin
                    pos_q <= '0;
                    if (final_ch) begin
                        // Tile complete; the next transfer starts a new tile.
                        ch_q    <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        ch_q    <= ch_inc;
                        state_q <= (ch_inc == eff_nch) ? ST_FINAL : ST_ACC;
                    end
                end else begin
                    pos_q   <= pos_q + 1'b1;
                    state_q <= final_ch ? ST_FINAL : ST_ACC;
                end
            end
        end
    end

    assign pready_o      = pready_q;
    assign conv_valid_o  = conv_valid_q;
    assign last_o        = last_q;
    assign conv_result_o = result_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_accumulator.sv
// ---------------------------------------------------------------------------
// tb_accumulator
//   Drives tiles of partial sums into accumulator, predicts each final result
//   from per-position column sums and checks outputs in a separate monitor.
// ---------------------------------------------------------------------------
module tb_accumulator;
    import acc_pkg::*;

    localparam int PSUM_W    = DEF_PSUM_W;
    localparam int ACC_W     = DEF_ACC_W;
    localparam int MAX_OFMAP = DEF_MAX_OFMAP;
    localparam int SIZE_W    = DEF_SIZE_W;
    localparam int CH_W      = DEF_CH_W;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic [PSUM_W-1:0] psum_i;
    logic              pvaild_i;
    logic              pready_o;
    logic [SIZE_W-1:0] ofmap_size;
    logic [CH_W-1:0]   ifmap_ch;
    logic              conv_valid_o;
    logic              last_o;
    logic [PSUM_W-1:0] conv_result_o;
    logic [1:0]        state_dbg_o;

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_s = 1'b1;   // rst_n as sampled by the most recent rising edge

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst_n;
    end

    accumulator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psum_i        (psum_i),
        .pvaild_i      (pvaild_i),
        .pready_o      (pready_o),
        .ofmap_size    (ofmap_size),
        .ifmap_ch      (ifmap_ch),
        .conv_valid_o  (conv_valid_o),
        .last_o        (last_o),
        .conv_result_o (conv_result_o),
        .state_dbg_o   (state_dbg_o)
    );

    // ---------------- scoreboard ----------------
    logic [PSUM_W:0] exp_q[$];   // {last, result}
    int              cyc_q[$];   // cycle in which the result must appear
    int              fixed_q[$]; // directed psums; random when empty
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Final result from a full column sum: clamp or two's-complement wrap.
    function automatic int model_res(input int s);
        int w;
`ifdef ACC_SATURATE_EN
        w = s;
        if (w > 127) w = 127;
        if (w < -128) w = -128;
`else
        w = s & 255;
        if (w > 127) w = w - 256;
`endif
        return w;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_s) begin
            chk("rst_pready", int'(pready_o), 0);
            chk("rst_valid", int'(conv_valid_o), 0);
            chk("rst_last", int'(last_o), 0);
            chk("rst_result", int'(conv_result_o), 0);
        end else begin
            chk("pready", int'(pready_o), 1);
            if (conv_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    logic [PSUM_W:0] e;
                    int              ec;
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    chk("latency", cyc, ec);
                    chk("result", int'(conv_result_o), int'(e[PSUM_W-1:0]));
                    chk("last", int'(last_o), int'(e[PSUM_W]));
                end
            end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
                chk("missing_valid", 0, 1);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic beat(input bit v, input int p, input int sz, input int nc);
        pvaild_i   = v;
        psum_i     = PSUM_W'(p);
        ofmap_size = SIZE_W'(sz);
        ifmap_ch   = CH_W'(nc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_beat();
        beat(1'b0, int'($urandom_range(255)), int'($urandom_range(1023)), int'($urandom_range(255)));
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        pvaild_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);   // pready_o rises on the first edge out of reset
        #1;
    endtask

    // One complete tile; configuration is scrambled after the first transfer
    // to confirm the latched values are the ones used.
    task automatic run_tile(input int nc, input int sz, input bit gap);
        int colsum[MAX_OFMAP];
        bit first;
        int ps;
        first = 1'b1;
        for (int c = 0; c <= nc; c++) begin
            for (int p = 0; p <= sz; p++) begin
                if (gap) idle_beat();
                if (fixed_q.size() > 0) ps = fixed_q.pop_front();
                else ps = int'($urandom_range(255)) - 128;
                if (c == 0) colsum[p] = ps;
                else colsum[p] = colsum[p] + ps;
                if (c == nc) begin
                    logic [PSUM_W-1:0] r;
                    r = PSUM_W'(model_res(colsum[p]));
                    exp_q.push_back({(p == sz), r});
                    cyc_q.push_back(cyc + 1);
                end
                if (first) beat(1'b1, ps, sz, nc);
                else beat(1'b1, ps, int'($urandom_range(1023)), int'($urandom_range(255)));
                first = 1'b0;
            end
        end
        pvaild_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        pvaild_i   = 1'b0;
        psum_i     = '0;
        ofmap_size = '0;
        ifmap_ch   = '0;
        do_reset(3);

        // Single channel: results pass straight through.
        fixed_q = '{5, -7, 0};
        run_tile(0, 2, 1'b0);
        idle_beat();

        // Two channels, single position: positive and negative overflow.
        fixed_q = '{100, 100};
        run_tile(1, 0, 1'b0);
        fixed_q = '{-100, -100};
        run_tile(1, 0, 1'b0);
        idle_beat();

        // Back-to-back random tiles, no idle cycle between them.
        run_tile(2, 3, 1'b0);
        run_tile(2, 3, 1'b0);
        idle_beat();

        // Gapped input.
        fixed_q = '{60, 70};
        run_tile(1, 0, 1'b1);
        idle_beat();

        // Abort partway through channel 1, then a clean tile of ones.
        for (int i = 0; i < 6; i++) beat(1'b1, 1, 3, 2);
        do_reset(1);
        for (int i = 0; i < 12; i++) fixed_q.push_back(1);
        run_tile(2, 3, 1'b0);
        idle_beat();

        // A few random small tiles with random gapping.
        for (int t = 0; t < 4; t++) begin
            run_tile(int'($urandom_range(3)), int'($urandom_range(6)), 1'($urandom_range(1)));
        end
        idle_beat();

        // Large tile: 16 channels by 784 positions.
        run_tile(15, 783, 1'b0);

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && cyc_q.size() > 0; i++) idle_beat();
        if (cyc_q.size() > 0) chk("drain", cyc_q.size(), 0);
        idle_beat();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
